// File: rtl/rgmii_pkg.sv
// Shared constants, FSM encoding and CRC-32 helpers for the RGMII receive framer.
package rgmii_pkg;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  // Residue of a good frame, in the normal (MSB-first) bit order.
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PREAMBLE = 2'd1;
  localparam logic [1:0] ST_DATA     = 2'd2;
  localparam logic [1:0] ST_DROP     = 2'd3;

  typedef enum logic [1:0] {
    StIdle     = ST_IDLE,
    StPreamble = ST_PREAMBLE,
    StData     = ST_DATA,
    StDrop     = ST_DROP
  } rx_state_e;

  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // One byte of the reflected CRC-32; bits are consumed LSB first as on the wire.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    logic [31:0] poly_r;
    c      = crc;
    poly_r = bit_rev32(CRC_POLY);
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) begin
        c = (c >> 1) ^ poly_r;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 register. The register already includes the byte
// presented with en_i on the following cycle, so the check adds no latency.
module crc32_d8
  import rgmii_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  logic [31:0] crc_d, crc_q;

  // Next CRC: reload at frame start, otherwise fold in the current byte.
  always_comb begin
    crc_d = crc_q;
    if (init_i) begin
      crc_d = CRC_INIT;
    end else if (en_i) begin
      crc_d = crc32_step(crc_q, data_i);
    end
  end

  // CRC state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      crc_q <= CRC_INIT;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/rgmii_rx_framer.sv
// RGMII receive framer: assembles DDR nibbles into bytes, strips preamble/SFD and
// emits a byte stream with sof/eof/err, frame length and good/bad pulses.
// Optional FCS check is built when RX_FCS_CHECK_EN is defined.
// Pipeline: stage A (raw byte/dv/er), stage B (classified byte), output registers.
module rgmii_rx_framer
  import rgmii_pkg::*;
#(
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned MAX_FRAME    = 1522,
  parameter int unsigned MAX_PREAMBLE = 15,
  parameter int unsigned LEN_W        = 11
) (
  input  logic             rgmii_rxc_1,
  input  logic             rst_n,
  input  logic [3:0]       rxd_rise,
  input  logic [3:0]       rxd_fall,
  input  logic             ctl_rise,
  input  logic             ctl_fall,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic             out_err,
  output logic [LEN_W-1:0] frame_len,
  output logic             good_pulse,
  output logic             bad_pulse
);

  localparam int unsigned      PreW   = $clog2(MAX_PREAMBLE + 2);
  localparam logic [PreW-1:0]  PreMax = PreW'(MAX_PREAMBLE);
  localparam logic [LEN_W-1:0] LenMin = LEN_W'(MIN_FRAME);
  localparam logic [LEN_W-1:0] LenMax = LEN_W'(MAX_FRAME);

  // Stage A
  logic [7:0] a_data_q;
  logic       a_dv_q, a_er_q, a_live_q;

  // FSM and frame accounting
  rx_state_e        state_d, state_q;
  logic [PreW-1:0]  pre_cnt_d, pre_cnt_q;
  logic [LEN_W-1:0] len_d, len_q;
  logic             er_seen_d, er_seen_q;
  logic             first_d, first_q;
  logic             wait_d, wait_q;

  // Stage B
  logic [7:0] b_data_d, b_data_q;
  logic       b_valid_d, b_valid_q;
  logic       b_sof_d, b_sof_q;
  logic       b_eof_d, b_eof_q;
  logic       b_drop_d, b_drop_q;

  // Output registers
  logic [7:0]       out_data_d, out_data_q;
  logic             out_valid_d, out_valid_q;
  logic             out_sof_d, out_sof_q;
  logic             out_eof_d, out_eof_q;
  logic             out_err_d, out_err_q;
  logic [LEN_W-1:0] frame_len_d, frame_len_q;
  logic             good_d, good_q;
  logic             bad_d, bad_q;

  logic fcs_bad;
  logic frame_bad;

  // Stage A: capture byte and decoded DV/ER every cycle.
  always_ff @(posedge rgmii_rxc_1 or negedge rst_n) begin
    if (!rst_n) begin
      a_data_q <= 8'h00;
      a_dv_q   <= 1'b0;
      a_er_q   <= 1'b0;
      a_live_q <= 1'b0;
    end else begin
      a_data_q <= {rxd_fall, rxd_rise};
      a_dv_q   <= ctl_rise;
      a_er_q   <= ctl_rise ^ ctl_fall;
      a_live_q <= 1'b1;
    end
  end

  // FSM next state and stage-B classification of the byte in stage A.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    len_d     = len_q;
    er_seen_d = er_seen_q;
    first_d   = first_q;
    wait_d    = wait_q;
    b_data_d  = a_data_q;
    b_valid_d = 1'b0;
    b_sof_d   = 1'b0;
    b_eof_d   = 1'b0;
    b_drop_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // After reset, ignore the tail of any frame already in progress.
        if (a_live_q && !a_dv_q) begin
          wait_d = 1'b0;
        end
        if (!wait_q && a_dv_q) begin
          if (a_data_q == PREAMBLE_BYTE) begin
            state_d   = StPreamble;
            pre_cnt_d = PreW'(1);
          end else begin
            state_d = StDrop;
          end
        end
      end
      StPreamble: begin
        if (!a_dv_q) begin
          state_d = StIdle;
        end else if (a_data_q == PREAMBLE_BYTE) begin
          if (pre_cnt_q >= PreMax) begin
            state_d  = StDrop;
            b_drop_d = 1'b1;
          end else begin
            pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end else if (a_data_q == SFD_BYTE && pre_cnt_q != '0) begin
          state_d   = StData;
          len_d     = '0;
          er_seen_d = 1'b0;
          first_d   = 1'b1;
        end else begin
          state_d  = StDrop;
          b_drop_d = 1'b1;
        end
      end
      StData: begin
        if (a_dv_q) begin
          b_valid_d = 1'b1;
          b_sof_d   = first_q;
          // Raw ctl_rise is the DV of the next byte: low means this one is last.
          b_eof_d   = !ctl_rise;
          first_d   = 1'b0;
          if (len_q != '1) begin
            len_d = len_q + 1'b1;
          end
          if (a_er_q) begin
            er_seen_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StDrop: begin
        if (!a_dv_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state register.
  always_ff @(posedge rgmii_rxc_1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame accounting and stage-B registers.
  always_ff @(posedge rgmii_rxc_1 or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt_q <= '0;
      len_q     <= '0;
      er_seen_q <= 1'b0;
      first_q   <= 1'b0;
      wait_q    <= 1'b1;
      b_data_q  <= 8'h00;
      b_valid_q <= 1'b0;
      b_sof_q   <= 1'b0;
      b_eof_q   <= 1'b0;
      b_drop_q  <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      len_q     <= len_d;
      er_seen_q <= er_seen_d;
      first_q   <= first_d;
      wait_q    <= wait_d;
      b_data_q  <= b_data_d;
      b_valid_q <= b_valid_d;
      b_sof_q   <= b_sof_d;
      b_eof_q   <= b_eof_d;
      b_drop_q  <= b_drop_d;
    end
  end

`ifdef RX_FCS_CHECK_EN
  logic        crc_init;
  logic        crc_en;
  logic [31:0] crc_q;

  assign crc_init = (state_q == StPreamble) && (state_d == StData);
  assign crc_en   = b_valid_d;

  crc32_d8 u_crc (
    .clk_i  (rgmii_rxc_1),
    .rst_ni (rst_n),
    .init_i (crc_init),
    .en_i   (crc_en),
    .data_i (a_data_q),
    .crc_o  (crc_q)
  );

  assign fcs_bad = (bit_rev32(crc_q) != CRC_RESIDUE);
`else
  assign fcs_bad = 1'b0;
`endif

  // Output next-state; len_q and er_seen_q already include the eof byte here.
  always_comb begin
    frame_bad   = er_seen_q | (len_q < LenMin) | (len_q > LenMax) | fcs_bad;
    out_valid_d = b_valid_q;
    out_data_d  = b_valid_q ? b_data_q : out_data_q;
    out_sof_d   = b_sof_q;
    out_eof_d   = b_eof_q;
    out_err_d   = b_eof_q & frame_bad;
    frame_len_d = b_eof_q ? len_q : frame_len_q;
    good_d      = b_eof_q & ~frame_bad;
    bad_d       = (b_eof_q & frame_bad) | b_drop_q;
  end

  // Output registers.
  always_ff @(posedge rgmii_rxc_1 or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_err_q   <= 1'b0;
      frame_len_q <= '0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_eof_q   <= out_eof_d;
      out_err_q   <= out_err_d;
      frame_len_q <= frame_len_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_sof    = out_sof_q;
  assign out_eof    = out_eof_q;
  assign out_err    = out_err_q;
  assign frame_len  = frame_len_q;
  assign good_pulse = good_q;
  assign bad_pulse  = bad_q;

endmodule

// File: tb/tb_rgmii_rx_framer.sv
// Scoreboard bench for rgmii_rx_framer: stimulus pushes expected output bytes and
// drop pulses into queues; a negedge monitor pops and compares.
module tb_rgmii_rx_framer;

  localparam int LEN_W = 11;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [3:0]       rxd_rise, rxd_fall;
  logic             ctl_rise, ctl_fall;
  logic [7:0]       out_data;
  logic             out_valid, out_sof, out_eof, out_err;
  logic [LEN_W-1:0] frame_len;
  logic             good_pulse, bad_pulse;

  rgmii_rx_framer dut (
    .rgmii_rxc_1 (clk),
    .rst_n       (rst_n),
    .rxd_rise    (rxd_rise),
    .rxd_fall    (rxd_fall),
    .ctl_rise    (ctl_rise),
    .ctl_fall    (ctl_fall),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_sof     (out_sof),
    .out_eof     (out_eof),
    .out_err     (out_err),
    .frame_len   (frame_len),
    .good_pulse  (good_pulse),
    .bad_pulse   (bad_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic       err;
    int         len;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         drop_q[$];
  logic [7:0] body[$];
  exp_t       mon_e;
  int         mon_c;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every out_valid byte and every stand-alone pulse must be expected.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("spurious_valid_data", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          mon_e = exp_q.pop_front();
          check("data", 32'(out_data), 32'(mon_e.data));
          check("sof", 32'(out_sof), 32'(mon_e.sof));
          check("eof", 32'(out_eof), 32'(mon_e.eof));
          check("latency_cycle", cyc, mon_e.cyc);
          if (mon_e.eof) begin
            check("err", 32'(out_err), 32'(mon_e.err));
            check("frame_len", 32'(frame_len), mon_e.len);
            check("good_bad", {30'b0, good_pulse, bad_pulse}, {30'b0, !mon_e.err, mon_e.err});
          end else begin
            check("pulse_mid_frame", {30'b0, good_pulse, bad_pulse}, 32'd0);
          end
        end
      end else if (good_pulse || bad_pulse || out_eof) begin
        if (good_pulse || out_eof || drop_q.size() == 0) begin
          check("stray_pulse", {29'b0, good_pulse, bad_pulse, out_eof}, 32'd0);
        end else begin
          mon_c = drop_q.pop_front();
          check("drop_pulse_cycle", cyc, mon_c);
        end
      end
    end
  end

  task automatic drive(input logic [7:0] b, input logic dv, input logic er);
    @(posedge clk);
    #1;
    rxd_rise = b[3:0];
    rxd_fall = b[7:4];
    ctl_rise = dv;
    ctl_fall = dv ^ er;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(8'h00, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c = 32'hFFFF_FFFF;
    for (int i = 0; i < body.size(); i++) begin
      for (int k = 0; k < 8; k++) begin
        if (c[0] ^ body[i][k]) c = (c >> 1) ^ 32'hEDB8_8320;
        else c = c >> 1;
      end
    end
    return c;
  endfunction

  task automatic build(input int n, input logic [7:0] seed);
    body.delete();
    for (int i = 0; i < n; i++) body.push_back(8'(i * 7) ^ seed);
  endtask

  task automatic add_fcs();
    logic [31:0] f;
    f = ~ref_crc();
    body.push_back(f[7:0]);
    body.push_back(f[15:8]);
    body.push_back(f[23:16]);
    body.push_back(f[31:24]);
  endtask

  // Preamble + SFD + body, then exactly one idle cycle.
  task automatic send_frame(input int npre, input int er_idx, input int exp_len,
                            input logic exp_err);
    exp_t e;
    for (int i = 0; i < npre; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < body.size(); i++) begin
      drive(body[i], 1'b1, i == er_idx);
      e.data = body[i];
      e.sof  = (i == 0);
      e.eof  = (i == body.size() - 1);
      e.err  = exp_err;
      e.len  = exp_len;
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
    idle(1);
  endtask

  // Raw dv=1 bytes (no SFD added); drop_idx marks the byte that must fire bad_pulse.
  task automatic send_raw(input int drop_idx);
    for (int i = 0; i < body.size(); i++) begin
      drive(body[i], 1'b1, 1'b0);
      if (i == drop_idx) drop_q.push_back(cyc + 3);
    end
    idle(1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_sof"}, 32'(out_sof), 32'd0);
    check({tag, "_out_eof"}, 32'(out_eof), 32'd0);
    check({tag, "_out_err"}, 32'(out_err), 32'd0);
    check({tag, "_frame_len"}, 32'(frame_len), 32'd0);
    check({tag, "_pulses"}, {30'b0, good_pulse, bad_pulse}, 32'd0);
  endtask

  task automatic drain(input string tag);
    idle(8);
    check({tag, "_exp_left"}, exp_q.size(), 32'd0);
    check({tag, "_drop_left"}, drop_q.size(), 32'd0);
    exp_q.delete();
    drop_q.delete();
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    rxd_rise = 4'h0;
    rxd_fall = 4'h0;
    ctl_rise = 1'b0;
    ctl_fall = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(3);

    // Good 64-byte frame: 60 payload + FCS.
    build(60, 8'h3C); add_fcs();
    send_frame(7, -1, 64, 1'b0);
    drain("good64");

    // Runt of 20 bytes.
    build(20, 8'hA1);
    send_frame(7, -1, 20, 1'b1);
    drain("runt");

    // Single-byte frame: sof and eof together, bad.
    build(1, 8'h42);
    send_frame(7, -1, 1, 1'b1);
    drain("one_byte");

    // ER on byte 30 of a 100-byte frame.
    build(96, 8'h5A); add_fcs();
    send_frame(7, 30, 100, 1'b1);
    drain("er_frame");

    // Oversize 1600-byte frame.
    build(1596, 8'h11); add_fcs();
    send_frame(7, -1, 1600, 1'b1);
    drain("oversize");

    // Exactly the maximum legal length.
    build(1518, 8'h77); add_fcs();
    send_frame(7, -1, 1522, 1'b0);
    drain("max_len");

    // Wrong byte after two preamble bytes: one bad pulse, no data.
    body.delete(); body.push_back(8'h55); body.push_back(8'h55); body.push_back(8'h12);
    send_raw(2);
    drain("pre_wrong");

    // 20 preamble bytes then SFD: the 16th 0x55 overflows.
    body.delete();
    for (int i = 0; i < 20; i++) body.push_back(8'h55);
    body.push_back(8'hD5);
    send_raw(15);
    drain("pre_long");

    // 15 preamble bytes are still legal.
    build(60, 8'h0F); add_fcs();
    send_frame(15, -1, 64, 1'b0);
    drain("pre_15");

    // Aborted in preamble, and non-preamble start from idle: no pulses.
    body.delete(); body.push_back(8'h55); body.push_back(8'h55); body.push_back(8'h55);
    send_raw(-1);
    body.delete(); body.push_back(8'h12); body.push_back(8'h55); body.push_back(8'hD5);
    body.push_back(8'h99);
    send_raw(-1);
    drain("silent_drops");

    // Back-to-back frames with one idle cycle and a one-byte preamble on the second.
    build(60, 8'hC3); add_fcs();
    send_frame(7, -1, 64, 1'b0);
    build(60, 8'h96); add_fcs();
    send_frame(1, -1, 64, 1'b0);
    drain("b2b");

    // Mid-frame reset during byte 10; the remainder holds a fake preamble + SFD.
    build(64, 8'h24);
    for (int i = 8; i <= 20; i++) body[i] = 8'h55;
    body[21] = 8'hD5;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < body.size(); i++) begin
      drive(body[i], 1'b1, 1'b0);
      if (i < 7) begin
        e.data = body[i]; e.sof = (i == 0); e.eof = 1'b0; e.err = 1'b0; e.len = 0;
        e.cyc = cyc + 3;
        exp_q.push_back(e);
      end
      if (i == 10) begin
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midreset");
      end
      if (i == 12) rst_n = 1'b1;
    end
    idle(1);
    build(60, 8'h81); add_fcs();
    send_frame(7, -1, 64, 1'b0);
    drain("after_reset");

    // Corrupted FCS.
    build(60, 8'h6E); add_fcs();
    body[63] = body[63] ^ 8'h10;
`ifdef RX_FCS_CHECK_EN
    send_frame(7, -1, 64, 1'b1);
`else
    send_frame(7, -1, 64, 1'b0);
`endif
    drain("bad_fcs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
